// File: rtl/clk_div_bank.sv
// ---------------------------------------------------------------------------
// clk_div_bank
//
// Multi-channel clock-enable generator. Each of NUM_CH channels divides
// refclk by a programmable divisor and produces a one-cycle strobe (clk_en)
// at a programmable phase plus a divided square wave (outclk). All channels
// restart together, phase-aligned, each time the bank leaves its settle
// window. The settle window follows reset release and every legal
// reconfiguration; `locked` marks the end of it.
//
// Ports
//   refclk     in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cfg_valid  in   configuration request
//   cfg_ready  out  request can be accepted (high only while running)
//   cfg_chan   in   target channel
//   cfg_div    in   new divisor (legal when >= 2)
//   cfg_phase  in   new strobe phase (legal when < cfg_div)
//   cfg_err    out  one-cycle pulse: accepted request was illegal, ignored
//   clk_en     out  per-channel one-cycle strobe, once per period
//   outclk     out  per-channel divided square wave
//   locked     out  outputs valid and phase-aligned
// ---------------------------------------------------------------------------
module clk_div_bank #(
    parameter  int NUM_CH      = 2,
    parameter  int DIV_W       = 16,
    parameter  int DEFAULT_DIV = 5,
    parameter  int LOCK_CYCLES = 16,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_chan,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] outclk,
    output logic              locked
);

    localparam int LK_W = $clog2(LOCK_CYCLES);

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [LK_W-1:0]   lock_q, lock_d;

    logic [DIV_W-1:0]  div_q   [NUM_CH];
    logic [DIV_W-1:0]  phase_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_q   [NUM_CH];

    logic              accept;
    logic              chan_ok;
    logic              legal;

    // Requests are only taken while running; anything presented during the
    // settle window simply waits at the requester.
    assign accept  = cfg_valid && (state_q == RUN);
    assign chan_ok = ({{(32-CH_W){1'b0}}, cfg_chan} < 32'(NUM_CH));
    assign legal   = chan_ok && (cfg_div >= DIV_W'(2)) && (cfg_phase < cfg_div);

    // locked and cfg_ready change exactly on the edges where the state
    // register does, so they come straight from that flop.
    assign locked    = (state_q == RUN);
    assign cfg_ready = (state_q == RUN);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SETTLE;
            lock_q  <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        lock_d  = lock_q;
        case (state_q)
            SETTLE: begin
                if (lock_q == LK_W'(LOCK_CYCLES - 1)) begin
                    state_d = RUN;
                    lock_d  = '0;
                end else begin
                    lock_d = lock_q + LK_W'(1);
                end
            end
            RUN: begin
                if (accept && legal) begin
                    state_d = SETTLE;
                    lock_d  = '0;
                end
            end
            default: begin
                state_d = SETTLE;
                lock_d  = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Channel datapath and config error pulse
    // -----------------------------------------------------------------------
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these arrays are a handful of flops, not RAM, so they are
            // reset; reset must restore the default divisor on every channel.
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]   <= DIV_W'(DEFAULT_DIV);
                phase_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
            clk_en  <= '0;
            outclk  <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept && !legal;
            for (int i = 0; i < NUM_CH; i++) begin
                if (state_q == SETTLE) begin
                    // Counters sit at zero so every channel starts its first
                    // period on the same edge once running.
                    cnt_q[i]  <= '0;
                    clk_en[i] <= 1'b0;
                    outclk[i] <= 1'b0;
                end else if (accept && legal) begin
                    // A legal accept wins over any wrap on the same edge.
                    if (cfg_chan == CH_W'(i)) begin
                        div_q[i]   <= cfg_div;
                        phase_q[i] <= cfg_phase;
                    end
                    cnt_q[i]  <= '0;
                    clk_en[i] <= 1'b0;
                    outclk[i] <= 1'b0;
                end else begin
                    clk_en[i] <= (cnt_q[i] == phase_q[i]);
                    // Odd divisors get the extra cycle in the low half.
                    outclk[i] <= (cnt_q[i] < (div_q[i] >> 1));
                    if (cnt_q[i] == div_q[i] - DIV_W'(1)) begin
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + DIV_W'(1);
                    end
                end
            end
        end
    end

endmodule
